rx_udp_buffer: RTL



---
 rtl/rx_udp_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/rx_udp_buffer.sv
// Receive payload buffer: captures UDP payload frames into a byte RAM with a
// length-descriptor FIFO, drops frames that do not fit, and lets the CPU drain frames.
module rx_udp_buffer #(
    parameter int DEPTH_LOG2 = 11,
    parameter int DESC_LOG2  = 2
) (
    input  logic                  RX_CLK,
    input  logic                  rst,
    input  logic                  in_data_v,
    input  logic [7:0]            in_data,
    output logic                  frame_avail,
    output logic [DEPTH_LOG2:0]   frame_len,
    input  logic                  rd_en,
    input  logic                  rd_skip,
    output logic [7:0]            rd_data,
    output logic                  rd_data_v,
    output logic                  rd_last,
    output logic [7:0]            drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int NDESC = 1 << DESC_LOG2;

    typedef logic [DEPTH_LOG2:0] ptr_t;
    typedef logic [DESC_LOG2:0]  dptr_t;

    typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DROP} wstate_t;
    typedef enum logic       {R_IDLE, R_READ}          rstate_t;

    logic [7:0] ram      [DEPTH];
    ptr_t       desc_mem [NDESC];

    wstate_t wstate;
    rstate_t rstate;
    ptr_t    wr_ptr, frm_start, rd_ptr, remain;
    dptr_t   desc_wr, desc_rd;

    logic  ram_full, desc_full;
    logic  ram_we, desc_push, drop_now;
    logic  rd_go, skip_go, desc_pop;
    ptr_t  cur_remain;
    dptr_t desc_count;

    assign ram_full    = (ptr_t'(wr_ptr - rd_ptr) == ptr_t'(DEPTH));
    assign desc_count  = dptr_t'(desc_wr - desc_rd);
    assign desc_full   = (desc_count == dptr_t'(NDESC));
    assign frame_avail = (desc_count != '0);
    assign frame_len   = frame_avail ? desc_mem[desc_rd[DESC_LOG2-1:0]] : '0;

    always_comb begin
        ram_we    = 1'b0;
        desc_push = 1'b0;
        drop_now  = 1'b0;
        case (wstate)
            W_IDLE, W_FRAME: ram_we = in_data_v && !ram_full;
            default:         ram_we = 1'b0;
        endcase
        if (wstate == W_FRAME && !in_data_v) begin
            desc_push = !desc_full;
            drop_now  = desc_full;
        end
        if (wstate == W_DROP && !in_data_v)
            drop_now = 1'b1;
    end

    always_ff @(posedge RX_CLK) begin
        if (ram_we)
            ram[wr_ptr[DEPTH_LOG2-1:0]] <= in_data;
        if (desc_push)
            desc_mem[desc_wr[DESC_LOG2-1:0]] <= ptr_t'(wr_ptr - frm_start);
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            wstate    <= W_IDLE;
            wr_ptr    <= '0;
            frm_start <= '0;
            desc_wr   <= '0;
            drop_cnt  <= '0;
        end else begin
            if (ram_we)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (desc_push)
                desc_wr <= desc_wr + dptr_t'(1);
            if (drop_now) begin
                wr_ptr <= frm_start;
                if (drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
            end
            case (wstate)
                W_IDLE: if (in_data_v) begin
                    frm_start <= wr_ptr;
                    wstate    <= ram_full ? W_DROP : W_FRAME;
                end
                W_FRAME: begin
                    if (!in_data_v)
                        wstate <= W_IDLE;
                    else if (ram_full)
                        wstate <= W_DROP;
                end
                W_DROP: if (!in_data_v)
                    wstate <= W_IDLE;
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // Remaining-byte count comes straight from the descriptor until the first read of a frame.
    assign cur_remain = (rstate == R_IDLE) ? frame_len : remain;
    assign skip_go    = frame_avail && rd_skip;
    assign rd_go      = frame_avail && rd_en && !rd_skip;
    assign desc_pop   = skip_go || (rd_go && cur_remain == ptr_t'(1));

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            rstate    <= R_IDLE;
            rd_ptr    <= '0;
            remain    <= '0;
            desc_rd   <= '0;
            rd_data   <= '0;
            rd_data_v <= 1'b0;
            rd_last   <= 1'b0;
        end else begin
            rd_data_v <= rd_go;
            rd_last   <= rd_go && (cur_remain == ptr_t'(1));
            if (desc_pop)
                desc_rd <= desc_rd + dptr_t'(1);
            if (skip_go) begin
                rd_ptr <= rd_ptr + cur_remain;
                rstate <= R_IDLE;
            end else if (rd_go) begin
                rd_data <= ram[rd_ptr[DEPTH_LOG2-1:0]];
                rd_ptr  <= rd_ptr + ptr_t'(1);
                remain  <= cur_remain - ptr_t'(1);
                rstate  <= (cur_remain == ptr_t'(1)) ? R_IDLE : R_READ;
            end
        end
    end

endmodule
